// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared opcode, encoding, field and state definitions
package instr_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_LUI = 4'd8;

  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;

  localparam logic LDR_ALU = 1'b0;
  localparam logic LDR_IMM = 1'b1;

  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 28;
  localparam int DST_HI  = 27;
  localparam int DST_LO  = 24;
  localparam int SRC1_HI = 23;
  localparam int SRC1_LO = 20;
  localparam int SRC2_HI = 19;
  localparam int SRC2_LO = 16;
  localparam int IMM_HI  = 15;
  localparam int IMM_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK
  } state_t;

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational opcode classification and immediate formatting
module instr_field_decode
  import instr_sequencer_pkg::*;
(
  input  logic [3:0]  opcode,
  input  logic [15:0] imm16,
  output logic [2:0]  alu_op,
  output logic        ldr_sel,
  output logic        is_nop,
  output logic        is_illegal,
  output logic [31:0] imm_out
);

  // Map opcode to ALU operation and LDR mux source; LUI shifts the immediate up,
  // everything else carries it zero-extended.
  always_comb begin
    alu_op     = ALU_PASS;
    ldr_sel    = LDR_ALU;
    is_nop     = 1'b0;
    is_illegal = 1'b0;
    imm_out    = {16'h0000, imm16};
    case (opcode)
      OP_NOP: is_nop = 1'b1;
      OP_MOV: alu_op = ALU_PASS;
      OP_ADD: alu_op = ALU_ADD;
      OP_SUB: alu_op = ALU_SUB;
      OP_AND: alu_op = ALU_AND;
      OP_OR:  alu_op = ALU_OR;
      OP_XOR: alu_op = ALU_XOR;
      OP_LDI: ldr_sel = LDR_IMM;
      OP_LUI: begin
        ldr_sel = LDR_IMM;
        imm_out = {imm16, 16'h0000};
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle decode/execute/writeback sequencer for the register bank
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instr_in,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [3:0]          destination,
  output logic [3:0]          source_1_sel,
  output logic [3:0]          source_2_sel,
  output logic [2:0]          alu_op,
  output logic                ldr_sel,
  output logic [31:0]         imm_out,
  output logic                wr_en,
  output logic                busy,
  output logic                illegal,
  output logic [RETIRE_W-1:0] retired
);

  state_t      state;
  state_t      next_state;
  logic        accept;
  logic [3:0]  opcode_q;
  logic [3:0]  dec_opcode;
  logic [2:0]  dec_alu_op;
  logic        dec_ldr_sel;
  logic        dec_is_nop;
  logic        dec_is_illegal;
  logic [31:0] dec_imm;

  // While idle the decoder looks at the incoming word so selects and the immediate
  // can be registered at the accept edge; afterwards it looks at the latched opcode.
  assign dec_opcode = (state == ST_IDLE) ? instr_in[OPC_HI:OPC_LO] : opcode_q;

  instr_field_decode u_decode (
    .opcode     (dec_opcode),
    .imm16      (instr_in[IMM_HI:IMM_LO]),
    .alu_op     (dec_alu_op),
    .ldr_sel    (dec_ldr_sel),
    .is_nop     (dec_is_nop),
    .is_illegal (dec_is_illegal),
    .imm_out    (dec_imm)
  );

  // State register; reset always returns to IDLE, abandoning any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and strobes; ready and the write strobe are masked by reset so a
  // reset landing on WRITEBACK never reaches the bank.
  always_comb begin
    next_state  = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    wr_en       = 1'b0;
    accept      = 1'b0;
    case (state)
      ST_IDLE: begin
        busy        = 1'b0;
        instr_ready = !reset;
        accept      = instr_valid && !reset;
        if (accept) begin
          next_state = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_is_nop || dec_is_illegal) begin
          next_state = ST_IDLE;
        end else begin
          next_state = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        next_state = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        wr_en      = !reset;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Field registers: selects and immediate load on accept, ALU controls load in DECODE
  // for instructions that execute; all hold otherwise so downstream muxes stay stable.
  always_ff @(posedge clk) begin
    if (reset) begin
      opcode_q     <= OP_NOP;
      destination  <= 4'd0;
      source_1_sel <= 4'd0;
      source_2_sel <= 4'd0;
      imm_out      <= 32'd0;
      alu_op       <= ALU_PASS;
      ldr_sel      <= LDR_ALU;
    end else begin
      if (accept) begin
        opcode_q     <= instr_in[OPC_HI:OPC_LO];
        destination  <= instr_in[DST_HI:DST_LO];
        source_1_sel <= instr_in[SRC1_HI:SRC1_LO];
        source_2_sel <= instr_in[SRC2_HI:SRC2_LO];
        imm_out      <= dec_imm;
      end
      if (state == ST_DECODE && !dec_is_nop && !dec_is_illegal) begin
        alu_op  <= dec_alu_op;
        ldr_sel <= dec_ldr_sel;
      end
    end
  end

  // Sticky illegal flag and retired counter; NOPs retire in DECODE, others in WRITEBACK.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      if (state == ST_DECODE && dec_is_illegal) begin
        illegal <= 1'b1;
      end
      if ((state == ST_DECODE && dec_is_nop) || state == ST_WRITEBACK) begin
        retired <= retired + RETIRE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid;

  logic        instr_ready;
  logic [3:0]  destination;
  logic [3:0]  source_1_sel;
  logic [3:0]  source_2_sel;
  logic [2:0]  alu_op;
  logic        ldr_sel;
  logic [31:0] imm_out;
  logic        wr_en;
  logic        busy;
  logic        illegal;
  logic [15:0] retired;

  logic        n_instr_ready;
  logic [3:0]  n_destination;
  logic [3:0]  n_source_1_sel;
  logic [3:0]  n_source_2_sel;
  logic [2:0]  n_alu_op;
  logic        n_ldr_sel;
  logic [31:0] n_imm_out;
  logic        n_wr_en;
  logic        n_busy;
  logic        n_illegal;
  logic [3:0]  n_retired;

  int checks = 0;
  int errors = 0;

  logic [3:0]  m_dst, m_src1, m_src2;
  logic [2:0]  m_alu;
  logic        m_ldr;
  logic        m_ill;
  int          m_ret;
  logic [2:0]  alu_tab [0:8] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd0};

  instr_sequencer #(.RETIRE_W(16)) dut (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .destination(destination), .source_1_sel(source_1_sel),
    .source_2_sel(source_2_sel), .alu_op(alu_op), .ldr_sel(ldr_sel), .imm_out(imm_out),
    .wr_en(wr_en), .busy(busy), .illegal(illegal), .retired(retired)
  );

  instr_sequencer #(.RETIRE_W(4)) dut_narrow (
    .clk(clk), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .instr_ready(n_instr_ready), .destination(n_destination), .source_1_sel(n_source_1_sel),
    .source_2_sel(n_source_2_sel), .alu_op(n_alu_op), .ldr_sel(n_ldr_sel), .imm_out(n_imm_out),
    .wr_en(n_wr_en), .busy(n_busy), .illegal(n_illegal), .retired(n_retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_dst = 4'd0; m_src1 = 4'd0; m_src2 = 4'd0;
    m_alu = 3'd0; m_ldr = 1'b0; m_ill = 1'b0; m_ret = 0;
  endtask

  task automatic check_held(input string tag);
    check({tag, "_dst"}, 32'(destination), 32'(m_dst));
    check({tag, "_src1"}, 32'(source_1_sel), 32'(m_src1));
    check({tag, "_src2"}, 32'(source_2_sel), 32'(m_src2));
    check({tag, "_alu"}, 32'(alu_op), 32'(m_alu));
    check({tag, "_ldr"}, 32'(ldr_sel), 32'(m_ldr));
    check({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
    check({tag, "_retired"}, 32'(retired), 32'(m_ret % 65536));
    check({tag, "_retired_n"}, 32'(n_retired), 32'(m_ret % 16));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      instr_valid = 1'b0;
      instr_in = $urandom;
      tick();
      check("idle_ready", 32'(instr_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check_held("idle");
    end
  endtask

  task automatic run_instr(input logic [31:0] word, input bit hold_valid, input logic [31:0] next_word);
    logic [3:0] op;
    logic [15:0] imm;
    op  = word[31:28];
    imm = word[15:0];
    check("pre_ready", 32'(instr_ready), 32'd1);
    instr_in = word;
    instr_valid = 1'b1;
    tick();
    instr_valid = hold_valid;
    instr_in = next_word;
    m_dst = word[27:24]; m_src1 = word[23:20]; m_src2 = word[19:16];
    check("dec_busy", 32'(busy), 32'd1);
    check("dec_ready", 32'(instr_ready), 32'd0);
    check("dec_wr_en", 32'(wr_en), 32'd0);
    check_held("dec");
    if (op == 4'd0 || op >= 4'd9) begin
      if (op == 4'd0) m_ret++;
      else m_ill = 1'b1;
      tick();
      check("short_ready", 32'(instr_ready), 32'd1);
      check("short_busy", 32'(busy), 32'd0);
      check("short_wr_en", 32'(wr_en), 32'd0);
      check_held("short");
    end else begin
      m_alu = alu_tab[op];
      m_ldr = (op == 4'd7 || op == 4'd8);
      tick();
      check("exe_wr_en", 32'(wr_en), 32'd0);
      check("exe_busy", 32'(busy), 32'd1);
      check_held("exe");
      tick();
      check("wb_wr_en", 32'(wr_en), 32'd1);
      check("wb_wr_en_n", 32'(n_wr_en), 32'd1);
      check("wb_ready", 32'(instr_ready), 32'd0);
      check_held("wb");
      if (op == 4'd7) check("wb_imm_ldi", imm_out, 32'(imm));
      if (op == 4'd8) check("wb_imm_lui", imm_out, 32'(imm) * 32'd65536);
      m_ret++;
      tick();
      check("post_wr_en", 32'(wr_en), 32'd0);
      check("post_ready", 32'(instr_ready), 32'd1);
      check_held("post");
    end
  endtask

  initial begin
    logic [31:0] w;
    reset = 1'b1;
    instr_valid = 1'b0;
    instr_in = 32'd0;
    model_reset();
    tick();
    tick();
    check("rst_ready_low", 32'(instr_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    reset = 1'b0;
    idle_cycles(3);
    check("rst_imm", imm_out, 32'd0);

    // directed: ADD, LUI, LDI
    run_instr(32'h2312_0000, 1'b0, $urandom);
    check("add_retired", 32'(retired), 32'd1);
    run_instr(32'h8F00_ABCD, 1'b0, $urandom);
    run_instr(32'h7000_1234, 1'b0, $urandom);
    idle_cycles(1);

    // illegal opcode followed by NOP with valid held high
    run_instr(32'hC456_7777, 1'b1, 32'h0ABC_DEF0);
    run_instr(32'h0ABC_DEF0, 1'b0, $urandom);
    check("ill_sticky", 32'(illegal), 32'd1);
    idle_cycles(2);

    // reset during EXECUTE of a SUB
    instr_in = 32'h3A12_0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    reset = 1'b1;
    model_reset();
    tick();
    check("rexe_ready_low", 32'(instr_ready), 32'd0);
    check("rexe_wr_en", 32'(wr_en), 32'd0);
    reset = 1'b0;
    tick();
    check("rexe_ready", 32'(instr_ready), 32'd1);
    check("rexe_wr_en2", 32'(wr_en), 32'd0);
    check_held("rexe");

    // reset coincident with WRITEBACK
    instr_in = 32'h2512_0000; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("rwb_wr_en", 32'(wr_en), 32'd0);
    model_reset();
    tick();
    check("rwb_wr_en2", 32'(wr_en), 32'd0);
    reset = 1'b0;
    tick();
    check("rwb_ready", 32'(instr_ready), 32'd1);
    check_held("rwb");

    // counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) begin
      w = $urandom;
      run_instr({4'h0, w[27:0]}, 1'b0, $urandom);
    end
    check("wrap_pre", 32'(n_retired), 32'd15);
    run_instr(32'h0000_0000, 1'b0, $urandom);
    check("wrap_zero", 32'(n_retired), 32'd0);
    run_instr(32'h0123_4567, 1'b0, $urandom);
    check("wrap_one", 32'(n_retired), 32'd1);

    // randomized instructions against the model
    for (int i = 0; i < 60; i++) begin
      w = $urandom;
      if (i % 3 != 0) w[31:28] = 4'($urandom_range(0, 8));
      run_instr(w, 1'b0, $urandom);
      idle_cycles($urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
